// File: rtl/bubble_sort_ctrl.sv
// ---------------------------------------------------------------------------
// bubble_sort_ctrl
//
// Sequential bubble-sort engine. N unsigned W-bit elements are loaded into an
// internal register array through a valid/ready input port, sorted ascending
// with a single shared compare/swap unit (one compare per clock), and then
// streamed out through a valid/ready output port in ascending order.
//
// Sorting stops early after a pass with no swaps. Equal elements are never
// swapped, so the sort is stable.
//
// Parameters
//   N            number of elements (2..16)
//   W            element width in bits
//
// Ports
//   clk_i        system clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   input element valid
//   in_ready_o   engine accepts an input element (load phase only)
//   in_data_i    input element
//   out_valid_o  output element valid (output phase only)
//   out_ready_i  downstream accepts the output element
//   out_data_o   output element, 0 outside the output phase
//   busy_o       high while sorting or streaming out
//   cmp_count_o  compare cycles used by the most recent sort (saturating)
//
// State table
//   IDLE | load phase: accept elements into mem[load_cnt]
//   SORT | one compare/swap of mem[idx], mem[idx+1] per cycle
//   OUT  | present mem[out_idx] until accepted, N elements in total
// ---------------------------------------------------------------------------
module bubble_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         busy_o,
  output logic [7:0]   cmp_count_o
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [IW-1:0] load_cnt_q, load_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] pass_q, pass_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          swapped_q, swapped_d;
  logic [7:0]    cmp_q, cmp_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          busy_q, busy_d;

  // Shared compare/swap datapath
  logic [IW-1:0] idx_p1;
  logic [IW-1:0] last_idx;
  logic [W-1:0]  elem_a;
  logic [W-1:0]  elem_b;
  logic          do_swap;

  assign idx_p1   = idx_q + IW'(1);
  // Each pass bubbles the largest remaining element to the end, so the
  // compare window shrinks by one per pass.
  assign last_idx = LAST_PASS - pass_q;
  assign elem_a   = mem_q[idx_q];
  assign elem_b   = mem_q[idx_p1];
  assign do_swap  = (elem_a > elem_b);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    out_idx_d  = out_idx_q;
    swapped_d  = swapped_q;
    cmp_d      = cmp_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          mem_d[load_cnt_q] = in_data_i;
          if (load_cnt_q == LAST_IDX) begin
            state_d    = SORT;
            load_cnt_d = '0;
            idx_d      = '0;
            pass_d     = '0;
            swapped_d  = 1'b0;
            cmp_d      = 8'd0;
          end else begin
            load_cnt_d = load_cnt_q + IW'(1);
          end
        end
      end

      SORT: begin
        if (do_swap) begin
          mem_d[idx_q]  = elem_b;
          mem_d[idx_p1] = elem_a;
        end
        if (cmp_q != 8'hFF) begin
          cmp_d = cmp_q + 8'd1;
        end
        if (idx_q < last_idx) begin
          idx_d     = idx_p1;
          swapped_d = swapped_q | do_swap;
        end else if (!(swapped_q || do_swap) || (pass_q == LAST_PASS)) begin
          // A clean pass means the array is already ordered.
          state_d   = OUT;
          out_idx_d = '0;
          idx_d     = '0;
          swapped_d = 1'b0;
        end else begin
          pass_d    = pass_q + IW'(1);
          idx_d     = '0;
          swapped_d = 1'b0;
        end
      end

      OUT: begin
        if (out_ready_i) begin
          if (out_idx_q == LAST_IDX) begin
            state_d    = IDLE;
            load_cnt_d = '0;
            out_idx_d  = '0;
          end else begin
            out_idx_d = out_idx_q + IW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: derive them from the next state so they line
    // up with the state they describe. In the final SORT cycle mem_d already
    // holds the last swap, so the first output element is correct.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
    out_data_d  = (state_d == OUT) ? mem_d[out_idx_d] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
      load_cnt_q  <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      out_idx_q   <= '0;
      swapped_q   <= 1'b0;
      cmp_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      load_cnt_q  <= load_cnt_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      out_idx_q   <= out_idx_d;
      swapped_q   <= swapped_d;
      cmp_q       <= cmp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign cmp_count_o = cmp_q;

endmodule
